error_frame_generator: RTL and testbench



---
 rtl/error_frame_generator_if.sv | 38 +++
 rtl/error_frame_generator.sv | 143 ++++++++++++++
 tb/tb_error_frame_generator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/error_frame_generator_if.sv
// Bus-side signals of the CAN error-frame generator; ERR_PASSIVE exists only
// when ERROR_PASSIVE_EN is defined.
interface error_frame_generator_if;
  logic       RX;
  logic       BIT_Error;
  logic       STUFF_Error;
  logic       FORM_Error;
  logic       ACK_Error;
  logic       CRC_Error;
`ifdef ERROR_PASSIVE_EN
  logic       ERR_PASSIVE;
`endif
  logic       TX;
  logic       ERR_BUSY;
  logic [2:0] ERR_CODE;
  logic       ERR_DONE;
  logic       ERR_STUCK;

`ifdef ERROR_PASSIVE_EN
  modport master (
    input  RX, BIT_Error, STUFF_Error, FORM_Error, ACK_Error, CRC_Error, ERR_PASSIVE,
    output TX, ERR_BUSY, ERR_CODE, ERR_DONE, ERR_STUCK
  );
  modport slave (
    output RX, BIT_Error, STUFF_Error, FORM_Error, ACK_Error, CRC_Error, ERR_PASSIVE,
    input  TX, ERR_BUSY, ERR_CODE, ERR_DONE, ERR_STUCK
  );
`else
  modport master (
    input  RX, BIT_Error, STUFF_Error, FORM_Error, ACK_Error, CRC_Error,
    output TX, ERR_BUSY, ERR_CODE, ERR_DONE, ERR_STUCK
  );
  modport slave (
    output RX, BIT_Error, STUFF_Error, FORM_Error, ACK_Error, CRC_Error,
    input  TX, ERR_BUSY, ERR_CODE, ERR_DONE, ERR_STUCK
  );
`endif
endinterface

// File: rtl/error_frame_generator.sv
// CAN error-frame generator: error flag, superposition wait, delimiter.
// Optional passive-flag support is enabled by defining ERROR_PASSIVE_EN.
module error_frame_generator #(
  parameter int FLAG_LEN     = 6,
  parameter int DELIM_LEN    = 8,
  parameter int SUPERPOS_MAX = 7
) (
  input  logic                    SP,
  input  logic                    reset,
  error_frame_generator_if.master bus
);

  localparam int MAXP = (FLAG_LEN > DELIM_LEN)
                        ? ((FLAG_LEN > SUPERPOS_MAX) ? FLAG_LEN : SUPERPOS_MAX)
                        : ((DELIM_LEN > SUPERPOS_MAX) ? DELIM_LEN : SUPERPOS_MAX);
  localparam int CW = $clog2(MAXP) + 1;

  typedef enum logic [1:0] {IDLE, FLAG, WAIT_REC, DELIM} state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt, w_base;
  logic            r_prev_rx, r_passive, w_passive;
  logic            r_tx, w_tx;
  logic            r_busy;
  logic [2:0]      r_code, w_code, w_cause;
  logic            r_done, w_done, r_stuck, w_stuck;
  logic            w_err, w_pass_det, w_eval_wait;

  assign w_err = bus.BIT_Error | bus.STUFF_Error | bus.FORM_Error |
                 bus.ACK_Error | bus.CRC_Error;

`ifdef ERROR_PASSIVE_EN
  assign w_pass_det = bus.ERR_PASSIVE;
`else
  assign w_pass_det = 1'b0;
`endif

  always_comb begin
    if      (bus.BIT_Error)   w_cause = 3'd1;
    else if (bus.STUFF_Error) w_cause = 3'd2;
    else if (bus.FORM_Error)  w_cause = 3'd3;
    else if (bus.ACK_Error)   w_cause = 3'd4;
    else                      w_cause = 3'd5;
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_passive   = r_passive;
    w_tx        = 1'b1;
    w_code      = r_code;
    w_done      = 1'b0;
    w_stuck     = 1'b0;
    w_eval_wait = 1'b0;
    w_base      = r_cnt;

    case (r_state)
      IDLE: begin
        if (w_err) begin
          w_state   = FLAG;
          w_cnt     = CW'(1);
          w_code    = w_cause;
          w_passive = w_pass_det;
          w_tx      = w_pass_det;
        end
      end
      FLAG: begin
        if (r_cnt == CW'(FLAG_LEN)) begin
          w_eval_wait = 1'b1;
          w_base      = '0;
        end else begin
          w_tx = r_passive;
          if (r_passive && (bus.RX != r_prev_rx)) w_cnt = CW'(1);
          else                                    w_cnt = r_cnt + 1'b1;
        end
      end
      WAIT_REC: w_eval_wait = 1'b1;
      DELIM: begin
        if (!bus.RX) begin
          w_state   = FLAG;
          w_cnt     = CW'(1);
          w_code    = 3'd3;
          w_passive = w_pass_det;
          w_tx      = w_pass_det;
        end else if (r_cnt + 1'b1 == CW'(DELIM_LEN)) begin
          w_state = IDLE;
          w_cnt   = '0;
          w_done  = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase

    // The flag-completion edge already samples RX as the first WAIT_REC bit.
    if (w_eval_wait) begin
      if (bus.RX) begin
        w_state = DELIM;
        w_cnt   = CW'(1);
      end else begin
        w_state = WAIT_REC;
        if (w_base + 1'b1 == CW'(SUPERPOS_MAX + 1)) begin
          w_stuck = 1'b1;
          w_cnt   = '0;
        end else begin
          w_cnt = w_base + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge SP) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_prev_rx <= 1'b1;
      r_passive <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_code    <= '0;
      r_done    <= 1'b0;
      r_stuck   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_prev_rx <= bus.RX;
      r_passive <= w_passive;
      r_tx      <= w_tx;
      r_busy    <= (w_state != IDLE);
      r_code    <= w_code;
      r_done    <= w_done;
      r_stuck   <= w_stuck;
    end
  end

  assign bus.TX        = r_tx;
  assign bus.ERR_BUSY  = r_busy;
  assign bus.ERR_CODE  = r_code;
  assign bus.ERR_DONE  = r_done;
  assign bus.ERR_STUCK = r_stuck;

endmodule

// File: tb/tb_error_frame_generator.sv
// Directed self-checking bench for error_frame_generator.
module tb_error_frame_generator;
  logic SP = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  error_frame_generator_if bus();

  error_frame_generator #(.FLAG_LEN(6), .DELIM_LEN(8), .SUPERPOS_MAX(7)) dut (
    .SP(SP), .reset(reset), .bus(bus)
  );

  always #5 SP = ~SP;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // errs = {bit, stuff, form, ack, crc}
  task automatic step(input logic rx, input logic [4:0] errs);
    bus.RX          = rx;
    bus.BIT_Error   = errs[4];
    bus.STUFF_Error = errs[3];
    bus.FORM_Error  = errs[2];
    bus.ACK_Error   = errs[1];
    bus.CRC_Error   = errs[0];
    @(posedge SP);
    #1;
  endtask

  task automatic flag_bits(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 5'b0);
      check("flag_tx", bus.TX, 1'b0);
      check("flag_busy", bus.ERR_BUSY, 1'b1);
    end
  endtask

  task automatic delim_done(input int n_before);
    for (int i = 0; i < n_before; i++) begin
      step(1'b1, 5'b0);
      check("delim_tx", bus.TX, 1'b1);
      check("delim_done_lo", bus.ERR_DONE, 1'b0);
      check("delim_busy", bus.ERR_BUSY, 1'b1);
      check("delim_stuck_lo", bus.ERR_STUCK, 1'b0);
    end
    step(1'b1, 5'b0);
    check("done_pulse", bus.ERR_DONE, 1'b1);
    check("done_busy", bus.ERR_BUSY, 1'b0);
    step(1'b1, 5'b0);
    check("done_clear", bus.ERR_DONE, 1'b0);
  endtask

  initial begin
`ifdef ERROR_PASSIVE_EN
    bus.ERR_PASSIVE = 1'b0;
`endif
    reset = 1'b1;
    step(1'b1, 5'b0);
    step(1'b1, 5'b0);
    check("rst_tx", bus.TX, 1'b1);
    check("rst_busy", bus.ERR_BUSY, 1'b0);
    check("rst_code", bus.ERR_CODE, 3'd0);
    check("rst_done", bus.ERR_DONE, 1'b0);
    check("rst_stuck", bus.ERR_STUCK, 1'b0);
    reset = 1'b0;

    // Form error at edge 3, done at edge 16
    step(1'b1, 5'b0);
    step(1'b1, 5'b0);
    check("idle_busy", bus.ERR_BUSY, 1'b0);
    step(1'b1, 5'b00100);
    check("form_tx", bus.TX, 1'b0);
    check("form_code", bus.ERR_CODE, 3'd3);
    check("form_busy", bus.ERR_BUSY, 1'b1);
    flag_bits(5);
    delim_done(7);

    // Bit + CRC simultaneously: bit wins
    step(1'b1, 5'b10001);
    check("prio_code", bus.ERR_CODE, 3'd1);
    check("prio_tx", bus.TX, 1'b0);
    flag_bits(5);
    delim_done(7);

    // Stuck dominant after flag; strobe during flag ignored
    step(1'b1, 5'b00010);
    check("ack_code", bus.ERR_CODE, 3'd4);
    flag_bits(4);
    step(1'b1, 5'b10000);
    check("ignore_code", bus.ERR_CODE, 3'd4);
    check("ignore_tx", bus.TX, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 5'b0);
      check("wait_tx", bus.TX, 1'b1);
      check("wait_stuck_lo", bus.ERR_STUCK, 1'b0);
      check("wait_busy", bus.ERR_BUSY, 1'b1);
    end
    step(1'b0, 5'b0);
    check("stuck_pulse", bus.ERR_STUCK, 1'b1);
    check("stuck_busy", bus.ERR_BUSY, 1'b1);
    delim_done(7);

    // Dominant in delimiter restarts flag as form error
    step(1'b1, 5'b01000);
    check("stuff_code", bus.ERR_CODE, 3'd2);
    flag_bits(5);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'b0);
      check("delim3_tx", bus.TX, 1'b1);
    end
    step(1'b0, 5'b0);
    check("restart_tx", bus.TX, 1'b0);
    check("restart_code", bus.ERR_CODE, 3'd3);
    check("restart_busy", bus.ERR_BUSY, 1'b1);
    flag_bits(5);
    delim_done(7);

    // Reset at third flag bit, then strobes coincident with reset
    step(1'b1, 5'b10000);
    step(1'b1, 5'b0);
    reset = 1'b1;
    step(1'b1, 5'b0);
    check("midrst_tx", bus.TX, 1'b1);
    check("midrst_busy", bus.ERR_BUSY, 1'b0);
    check("midrst_code", bus.ERR_CODE, 3'd0);
    check("midrst_done", bus.ERR_DONE, 1'b0);
    step(1'b1, 5'b11111);
    check("rststrobe_busy", bus.ERR_BUSY, 1'b0);
    check("rststrobe_code", bus.ERR_CODE, 3'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'b0);
      check("postrst_done", bus.ERR_DONE, 1'b0);
      check("postrst_busy", bus.ERR_BUSY, 1'b0);
      check("postrst_tx", bus.TX, 1'b1);
    end

`ifdef ERROR_PASSIVE_EN
    // Passive flag: TX stays recessive, exits after 6 equal RX bits
    bus.ERR_PASSIVE = 1'b1;
    step(1'b1, 5'b00010);
    bus.ERR_PASSIVE = 1'b0;
    check("pas_code", bus.ERR_CODE, 3'd4);
    check("pas_tx", bus.TX, 1'b1);
    check("pas_busy", bus.ERR_BUSY, 1'b1);
    step(1'b0, 5'b0);
    check("pas_tx0", bus.TX, 1'b1);
    step(1'b1, 5'b0);
    check("pas_tx1", bus.TX, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'b0);
      check("pas_flag_tx", bus.TX, 1'b1);
      check("pas_flag_done", bus.ERR_DONE, 1'b0);
    end
    delim_done(7);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
